alu_seq: RTL and testbench

- Parametrised, handshaked successor to the processor's combinational ALU. Keeps the same 8-bit opcode numbering for arithmetic, logic and shift/rotate ops.
- Adds a registered result and flags stage with valid/ready flow control, plus an iterative multi-bit shift/rotate engine.
- Holds a persistent ZCSPV flag register, so carry chains across back-to-back operations.
- Sits between the decode stage and the register writeback.

---
 rtl/alu_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with a persistent ZCSPV flag
// register and an optional one-bit-per-cycle shift/rotate engine.
//
// Ports:
//   clkout              system clock (rising edge)
//   rst                 asynchronous active-high reset
//   in_valid / in_ready request handshake; opcode, A, B, val, cin captured on accept
//   opcode [7:0]        operation select (1..31 legal, others flagged via out_err)
//   A, B [DATA_W-1:0]   operands
//   val  [DATA_W-1:0]   immediate operand, or shift count in val[SHW-1:0]
//   cin                 external carry-in (used only when CIN_SRC=1)
//   out_valid/out_ready result handshake; result/flags/out_err stable while held
//   result [DATA_W-1:0] registered result
//   flags  [4:0]        registered {Z,C,S,P,V}
//   out_err             illegal opcode indicator, qualified by out_valid
//   busy                iterative shift in progress
module alu_seq #(
    parameter int DATA_W     = 32,
    parameter int SHW        = $clog2(DATA_W),
    parameter int CIN_SRC    = 0,
    parameter int ITER_SHIFT = 1
) (
    input  logic              clkout,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] val,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        flags,
    output logic              out_err,
    output logic              busy
);
    localparam int M = DATA_W - 1;
    // A barrel shift is an unrolled chain of single-bit steps; none in iterative mode.
    localparam int BAR_STEPS = (ITER_SHIFT != 0) ? 0 : DATA_W - 1;

    localparam logic [7:0] OP_ADD = 8'd1,  OP_ADI = 8'd2,  OP_ACA = 8'd3,  OP_ACI = 8'd4;
    localparam logic [7:0] OP_SUB = 8'd5,  OP_SCI = 8'd6,  OP_SBI = 8'd7,  OP_SCA = 8'd8;
    localparam logic [7:0] OP_XNR = 8'd9,  OP_XNI = 8'd10, OP_XOR = 8'd11, OP_XRI = 8'd12;
    localparam logic [7:0] OP_AND = 8'd13, OP_ANI = 8'd14, OP_ORA = 8'd15, OP_ORI = 8'd16;
    localparam logic [7:0] OP_NOT = 8'd17, OP_NEG = 8'd18, OP_SRL = 8'd19, OP_SLL = 8'd20;
    localparam logic [7:0] OP_ASR = 8'd21, OP_ASL = 8'd22, OP_SRC = 8'd23, OP_SLC = 8'd24;
    localparam logic [7:0] OP_ROR = 8'd25, OP_ROL = 8'd26, OP_RRC = 8'd27, OP_RLC = 8'd28;
    localparam logic [7:0] OP_CLR = 8'd29, OP_INC = 8'd30, OP_DEC = 8'd31;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d, shreg_q, shreg_d;
    logic [4:0]        flags_q, flags_d;
    logic              out_valid_q, out_valid_d, err_q, err_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [7:0]        op_q, op_d;
    logic              fill_q, fill_d, cout_q, cout_d, vacc_q, vacc_d;

    // One single-bit shift step. Returns {msb_changed (ASL only), bit_out, data}.
    // 'ring' is the extra ring bit for RRC/RLC; 'fill' is the SRC/SLC fill bit.
    function automatic logic [DATA_W+1:0] shift_step(input logic [7:0] op,
                                                     input logic [DATA_W-1:0] d,
                                                     input logic ring,
                                                     input logic fill);
        logic [DATA_W+1:0] r;
        r = {1'b0, ring, d};
        case (op)
            OP_SRL: r = {1'b0, d[0], 1'b0, d[M:1]};
            OP_SLL: r = {1'b0, d[M], d[M-1:0], 1'b0};
            OP_ASR: r = {1'b0, d[0], d[M], d[M:1]};
            OP_ASL: r = {d[M] ^ d[M-1], d[M], d[M-1:0], 1'b0};
            OP_SRC: r = {1'b0, d[0], fill, d[M:1]};
            OP_SLC: r = {1'b0, d[M], d[M-1:0], fill};
            OP_ROR: r = {1'b0, d[0], d[0], d[M:1]};
            OP_ROL: r = {1'b0, d[M], d[M-1:0], d[M]};
            OP_RRC: r = {1'b0, d[0], ring, d[M:1]};
            OP_RLC: r = {1'b0, d[M], d[M-1:0], ring};
            default: r = {1'b0, ring, d};
        endcase
        return r;
    endfunction

    function automatic logic [4:0] mk_flags(input logic [DATA_W-1:0] r, input logic c,
                                            input logic v);
        return {(r == '0), c, r[M], ^r, v};
    endfunction

    logic              c_flag, cin_eff, is_shift, accept;
    logic [SHW-1:0]    n_in;
    logic [DATA_W-1:0] op2, add_x, add_y, sub_y, alu_res, bar_res;
    logic              add_ci, sub_ci, add_v, sub_v, alu_c, alu_v, alu_err, bar_c, bar_v;
    logic [DATA_W:0]   add_sum, sub_dif;
    logic [4:0]        alu_flags;
    logic [DATA_W+1:0] sh_st;

    assign c_flag   = flags_q[3];
    assign cin_eff  = (CIN_SRC != 0) ? cin : c_flag;
    assign n_in     = val[SHW-1:0];
    assign is_shift = (opcode >= OP_SRL) && (opcode <= OP_RLC);
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_SHIFT);

    // Immediate forms take val as the second operand.
    always_comb begin
        op2 = B;
        case (opcode)
            OP_ADI, OP_ACI, OP_SCI, OP_SBI, OP_XNI, OP_XRI, OP_ANI, OP_ORI: op2 = val;
            default: op2 = B;
        endcase
    end

    // Shared adder and subtractor; carry/borrow taken from the extra top bit.
    always_comb begin
        add_x  = A;
        add_y  = op2;
        add_ci = 1'b0;
        sub_y  = op2;
        sub_ci = 1'b0;
        case (opcode)
            OP_ACA, OP_ACI: add_ci = cin_eff;
            OP_INC:         add_y  = {{(DATA_W-1){1'b0}}, 1'b1};
            OP_NEG: begin
                add_x  = ~A;
                add_y  = '0;
                add_ci = 1'b1;
            end
            OP_SCA, OP_SCI: sub_ci = cin_eff;
            OP_DEC:         sub_y  = {{(DATA_W-1){1'b0}}, 1'b1};
            default: ;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_ci};
        sub_dif = {1'b0, A} - {1'b0, sub_y} - {{DATA_W{1'b0}}, sub_ci};
        add_v   = (add_x[M] == add_y[M]) && (add_sum[M] != add_x[M]);
        sub_v   = (A[M] != sub_y[M]) && (sub_dif[M] != A[M]);
    end

    // Single-cycle shift path. In iterative mode this only serves n=0 (result=A, C kept).
    always_comb begin
        bar_res = A;
        bar_c   = c_flag;
        bar_v   = 1'b0;
        for (int i = 0; i < BAR_STEPS; i++) begin
            logic [DATA_W+1:0] st;
            if (i < int'(n_in)) begin
                st      = shift_step(opcode, bar_res, bar_c, c_flag);
                bar_res = st[DATA_W-1:0];
                bar_c   = st[DATA_W];
                bar_v   = bar_v | st[DATA_W+1];
            end
        end
    end

    always_comb begin
        alu_res = A;
        alu_c   = c_flag;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (opcode)
            OP_ADD, OP_ADI, OP_ACA, OP_ACI, OP_INC, OP_NEG: begin
                alu_res = add_sum[M:0];
                alu_c   = add_sum[DATA_W];
                alu_v   = add_v;
            end
            OP_SUB, OP_SBI, OP_SCA, OP_SCI, OP_DEC: begin
                alu_res = sub_dif[M:0];
                alu_c   = sub_dif[DATA_W];
                alu_v   = sub_v;
            end
            OP_XNR, OP_XNI: alu_res = ~(A ^ op2);
            OP_XOR, OP_XRI: alu_res = A ^ op2;
            OP_AND, OP_ANI: alu_res = A & op2;
            OP_ORA, OP_ORI: alu_res = A | op2;
            OP_NOT:         alu_res = ~A;
            OP_CLR:         alu_res = '0;
            OP_SRL, OP_SLL, OP_ASR, OP_ASL, OP_SRC,
            OP_SLC, OP_ROR, OP_ROL, OP_RRC, OP_RLC: begin
                alu_res = bar_res;
                alu_c   = bar_c;
                alu_v   = bar_v;
            end
            default: alu_err = 1'b1;
        endcase
        // Illegal opcodes leave the whole flag register untouched.
        alu_flags = alu_err ? flags_q : mk_flags(alu_res, alu_c, alu_v);
    end

    // Iterative engine: cout_q doubles as the RRC/RLC ring bit and the last bit out.
    assign sh_st = shift_step(op_q, shreg_q, cout_q, fill_q);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        fill_d      = fill_q;
        cout_d      = cout_q;
        vacc_d      = vacc_q;
        case (state_q)
            S_IDLE: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
                if (accept) begin
                    if (is_shift && (ITER_SHIFT != 0) && (n_in != '0)) begin
                        state_d = S_SHIFT;
                        shreg_d = A;
                        cnt_d   = n_in;
                        op_d    = opcode;
                        fill_d  = c_flag;
                        cout_d  = c_flag;
                        vacc_d  = 1'b0;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        err_d       = alu_err;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = sh_st[DATA_W-1:0];
                cout_d  = sh_st[DATA_W];
                vacc_d  = vacc_q | sh_st[DATA_W+1];
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d     = S_IDLE;
                    result_d    = sh_st[DATA_W-1:0];
                    flags_d     = mk_flags(sh_st[DATA_W-1:0], sh_st[DATA_W],
                                           vacc_q | sh_st[DATA_W+1]);
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            fill_q      <= 1'b0;
            cout_q      <= 1'b0;
            vacc_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            cout_q      <= cout_d;
            vacc_q      <= vacc_d;
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (DATA_W=8, CIN_SRC=0, ITER_SHIFT=1).
// Flags are compared as {Z,C,S,P,V}.
module tb_alu_seq;
    logic       clkout = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] opcode = 8'd0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic [7:0] val = 8'd0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [4:0] flags;
    logic       out_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.DATA_W(8), .CIN_SRC(0), .ITER_SHIFT(1)) dut (
        .clkout(clkout), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .A(A), .B(B), .val(val), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .out_err(out_err), .busy(busy)
    );

    always #5 clkout = ~clkout;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] v);
        opcode   = op;
        A        = a;
        B        = b;
        val      = v;
        in_valid = 1'b1;
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] v);
        int n;
        drive(op, a, b, v);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clkout);
            #1;
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1);
        @(posedge clkout);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clkout);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] v,
                          input logic [7:0] exp_res, input logic [4:0] exp_flags,
                          input logic exp_err, input int exp_lat);
        int lat;
        send(op, a, b, v);
        check_eq({tag, "_busy"}, busy, (exp_lat > 1));
        // Operands moving after acceptance must not disturb the operation.
        A   = 8'hA5;
        B   = 8'h5A;
        val = 8'h00;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clkout);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_flags"}, flags, exp_flags);
        check_eq({tag, "_err"}, out_err, exp_err);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clkout);
        #1;
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Signed overflow into MSB
        run_op("add_ovf", 8'd1, 8'h7F, 8'h01, 8'h00, 8'h80, 5'b00111, 1'b0, 1);

        // Back-to-back ADD then ACA consuming the fresh carry, full throughput
        @(posedge clkout);
        #1;
        out_ready = 1'b1;
        drive(8'd1, 8'hFF, 8'h01, 8'h00);
        check_eq("b2b_rdy_add", in_ready, 1);
        @(posedge clkout);
        #1;
        check_eq("b2b_add_valid", out_valid, 1);
        check_eq("b2b_add_res", result, 8'h00);
        check_eq("b2b_add_flags", flags, 5'b11000);
        drive(8'd3, 8'h00, 8'h00, 8'h00);
        check_eq("b2b_rdy_aca", in_ready, 1);
        @(posedge clkout);
        #1;
        check_eq("b2b_aca_valid", out_valid, 1);
        check_eq("b2b_aca_res", result, 8'h01);
        check_eq("b2b_aca_flags", flags, 5'b00010);
        in_valid = 1'b0;
        @(posedge clkout);
        #1;
        check_eq("b2b_drained", out_valid, 0);
        out_ready = 1'b0;

        // Iterative shifts
        run_op("rrc1", 8'd27, 8'h01, 8'h00, 8'h01, 8'h00, 5'b11000, 1'b0, 2);
        run_op("rol3", 8'd26, 8'h81, 8'h00, 8'h03, 8'h0C, 5'b00000, 1'b0, 4);

        // Result held under back-pressure; a pending request must wait
        send(8'd5, 8'h00, 8'h01, 8'h00);
        drive(8'h40, 8'h5A, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_res", result, 8'hFF);
            check_eq("hold_flags", flags, 5'b01100);
            @(posedge clkout);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", in_ready, 1);
        @(posedge clkout);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("illegal_valid", out_valid, 1);
        check_eq("illegal_err", out_err, 1);
        check_eq("illegal_res", result, 8'h5A);
        check_eq("illegal_flags", flags, 5'b01100);
        consume();

        // Assorted arithmetic / logic
        run_op("xri_keepc", 8'd12, 8'hF0, 8'h00, 8'h0F, 8'hFF, 5'b01100, 1'b0, 1);
        run_op("sca_borrow", 8'd8, 8'h05, 8'h04, 8'h00, 8'h00, 5'b10000, 1'b0, 1);
        run_op("aci_carry", 8'd4, 8'hF0, 8'h00, 8'h20, 8'h10, 5'b01010, 1'b0, 1);
        run_op("neg_80", 8'd18, 8'h80, 8'h00, 8'h00, 8'h80, 5'b00111, 1'b0, 1);
        run_op("inc_ff", 8'd30, 8'hFF, 8'h00, 8'h00, 8'h00, 5'b11000, 1'b0, 1);
        run_op("clr_keepc", 8'd29, 8'h33, 8'h00, 8'h00, 8'h00, 5'b11000, 1'b0, 1);
        run_op("dec_00", 8'd31, 8'h00, 8'h00, 8'h00, 8'hFF, 5'b01100, 1'b0, 1);
        run_op("sbi_ovf", 8'd7, 8'h80, 8'h00, 8'h01, 8'h7F, 5'b00011, 1'b0, 1);

        // More shift flavours
        run_op("asl2_v", 8'd22, 8'h40, 8'h00, 8'h02, 8'h00, 5'b11001, 1'b0, 3);
        run_op("slc2_fill", 8'd24, 8'h00, 8'h00, 8'h02, 8'h03, 5'b00000, 1'b0, 3);
        run_op("asr3", 8'd21, 8'h80, 8'h00, 8'h03, 8'hF0, 5'b00100, 1'b0, 4);
        run_op("rlc1", 8'd28, 8'h80, 8'h00, 8'h01, 8'h00, 5'b11000, 1'b0, 2);
        run_op("src1_fill", 8'd23, 8'h00, 8'h00, 8'h01, 8'h80, 5'b00110, 1'b0, 2);
        run_op("ror1", 8'd25, 8'h01, 8'h00, 8'h01, 8'h80, 5'b01110, 1'b0, 2);
        run_op("srl0_keepc", 8'd19, 8'h03, 8'h00, 8'h00, 8'h03, 5'b01000, 1'b0, 1);

        // Asynchronous reset in the middle of a long shift
        send(8'd20, 8'h01, 8'h00, 8'h07);
        @(posedge clkout);
        #1;
        @(posedge clkout);
        #1;
        check_eq("midrst_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_res", result, 8'h00);
        check_eq("midrst_flags", flags, 5'b00000);
        check_eq("midrst_err", out_err, 0);
        @(posedge clkout);
        #1;
        rst = 1'b0;
        #1;
        check_eq("postrst_in_ready", in_ready, 1);
        run_op("sll0_after_rst", 8'd20, 8'h01, 8'h00, 8'h00, 8'h01, 5'b00010, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
